// File: rtl/ebi_pkg.sv
// Shared definitions for the EBI interrupt aggregator: register map, source
// bit positions, FSM encoding and the vector priority encoder.
package ebi_pkg;

  localparam logic [1:0] ADDR_IPR = 2'd0;
  localparam logic [1:0] ADDR_IMR = 2'd1;
  localparam logic [1:0] ADDR_ITR = 2'd2;
  localparam logic [1:0] ADDR_IVR = 2'd3;

  localparam int SRC_UARTA = 0;
  localparam int SRC_UARTB = 1;
  localparam int SRC_UARTC = 2;
  localparam int SRC_UARTD = 3;
  localparam int SRC_UARTE = 4;
  localparam int SRC_UARTF = 5;
  localparam int SRC_CAN0  = 6;
  localparam int SRC_NAND  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } irq_state_e;

  // Lowest set bit index wins, so UART A has the highest priority.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_src_cond.sv
// One interrupt source: two-flop synchroniser, edge/level qualification and
// a write-1-to-clear pending flop where a coincident set wins.
module irq_src_cond import ebi_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic edge_mode,
  input  logic clr,
  output logic pend
);

  logic s1_r, s2_r, prev_r, pend_r;
  logic set_s;

  // Set request from the synchronised source
  always_comb begin
    set_s = 1'b0;
    if (edge_mode) begin
      set_s = s2_r & ~prev_r;
    end else begin
      set_s = s2_r;
    end
  end

  // Synchroniser, edge history and pending flop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      prev_r <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      s1_r   <= src;
      s2_r   <= s1_r;
      prev_r <= s2_r;
      pend_r <= set_s | (pend_r & ~clr);
    end
  end

  assign pend = pend_r;

endmodule

// File: rtl/ebi_irq_ctrl.sv
// Interrupt aggregator: per-source pending/mask/trigger registers on the EBI
// register bus, lowest-index vector, and a holdoff FSM driving irq_n.
module ebi_irq_ctrl import ebi_pkg::*; #(
  parameter int NSRC    = 8,
  parameter int HOLDOFF = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] irq_src,
  input  logic            sel,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic            re,
  input  logic [31:0]     write_data,
  output logic [31:0]     read_data,
  output logic            irq_n
);

  generate
    if (NSRC < 1 || NSRC > 16 || HOLDOFF < 1 || HOLDOFF > 255) begin : g_param_check
      $error("ebi_irq_ctrl: NSRC must be 1..16 and HOLDOFF 1..255");
    end
  endgenerate

  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

  logic [NSRC-1:0] ipr_s, imr_r, itr_r, clr_s;
  logic [15:0]     act16_s;
  logic [3:0]      vec_idx_s;
  logic            active_s;
  logic [31:0]     rdata_s;
  logic            wdata_unused_s;
  irq_state_e      state_r, state_nxt_s;
  logic [7:0]      cnt_r, cnt_nxt_s;
  logic            irq_n_r, irq_n_nxt_s;

  assign wdata_unused_s = ^write_data;

  // Write-1-to-clear strobes for the pending bits
  always_comb begin
    clr_s = {NSRC{1'b0}};
    if (sel && we && (addr == ADDR_IPR)) begin
      clr_s = write_data[NSRC-1:0];
    end else begin
      clr_s = {NSRC{1'b0}};
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    irq_src_cond u_cond (
      .clk       (clk),
      .rst_n     (rst_n),
      .src       (irq_src[i]),
      .edge_mode (itr_r[i]),
      .clr       (clr_s[i]),
      .pend      (ipr_s[i])
    );
  end

  // Masked pending vector widened for the shared priority encoder
  always_comb begin
    act16_s = 16'h0000;
    act16_s[NSRC-1:0] = ipr_s & imr_r;
  end

  assign active_s  = |act16_s;
  assign vec_idx_s = lowest_set(act16_s);

  // Mask and trigger-mode registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imr_r <= {NSRC{1'b0}};
      itr_r <= {NSRC{1'b0}};
    end else begin
      if (sel && we && (addr == ADDR_IMR)) imr_r <= write_data[NSRC-1:0];
      if (sel && we && (addr == ADDR_ITR)) itr_r <= write_data[NSRC-1:0];
    end
  end

  // Register read mux; shows pre-edge state during a coincident write
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (sel && re) begin
      case (addr)
        ADDR_IPR: rdata_s = 32'(ipr_s);
        ADDR_IMR: rdata_s = 32'(imr_r);
        ADDR_ITR: rdata_s = 32'(itr_r);
        ADDR_IVR: rdata_s = active_s ? {1'b1, 27'd0, vec_idx_s} : 32'h0000_0000;
        default:  rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign read_data = rdata_s;

  // Next-state logic; HOLD enforces a minimum high time before reassertion
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (active_s) state_nxt_s = ST_ASSERT;
        else          state_nxt_s = ST_IDLE;
      end
      ST_ASSERT: begin
        if (!active_s) begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = HOLD_LOAD;
        end else begin
          state_nxt_s = ST_ASSERT;
        end
      end
      ST_HOLD: begin
        if (cnt_r == 8'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
    irq_n_nxt_s = (state_nxt_s != ST_ASSERT);
  end

  // FSM state, holdoff counter and registered interrupt pin
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      irq_n_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      irq_n_r <= irq_n_nxt_s;
    end
  end

  assign irq_n = irq_n_r;

endmodule
